// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared address map, CON bit positions and FSM state encoding
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package uart_pkg;

   localparam logic [31:0] UART_TXD_ADDR = 32'h4000_0018;
   localparam logic [31:0] UART_RXD_ADDR = 32'h4000_001C;
   localparam logic [31:0] UART_CON_ADDR = 32'h4000_0020;

   localparam int CON_RX_VALID = 0;
   localparam int CON_TX_BUSY  = 1;
   localparam int CON_TX_DONE  = 2;
   localparam int CON_RX_OVR   = 3;
   localparam int CON_RX_IE    = 4;
   localparam int CON_TX_IE    = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_rx_core.sv
// ============================================================================
// uart_rx_core : rx synchronizer, 16x oversampled receive FSM, shift register
// Rev 1.0      : initial release
// ============================================================================
`default_nettype none

module uart_rx_core
   import uart_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       tick16_i,
   input  logic       rx_i,
   output logic       byte_strobe_o,
   output logic [7:0] byte_out_o,
   output logic       frame_err_o
);

   logic [1:0]  sync_q;
   logic        rx_s;
   uart_state_t state_q, state_d;
   logic [3:0]  tick_q, tick_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic        strobe_q, strobe_d;
   logic        err_q, err_d;

   assign rx_s = sync_q[1];

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q   <= 2'b11;
         state_q  <= IDLE;
         tick_q   <= 4'd0;
         bit_q    <= 3'd0;
         shift_q  <= 8'd0;
         strobe_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         sync_q   <= {sync_q[0], rx_i};
         state_q  <= state_d;
         tick_q   <= tick_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         strobe_q <= strobe_d;
         err_q    <= err_d;
      end
   end

   // The 4-bit tick counter wraps on its own, so tick 8 of START lands at the
   // bit centre and every later 16-tick boundary stays centred.
   always_comb begin
      state_d  = state_q;
      tick_d   = tick_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      strobe_d = 1'b0;
      err_d    = err_q;
      case (state_q)
         IDLE: begin
            if (!rx_s) begin
               state_d = START;
               tick_d  = 4'd0;
            end
         end
         START: begin
            if (tick16_i) begin
               tick_d = tick_q + 4'd1;
               if (tick_q == 4'd7) begin
                  tick_d  = 4'd0;
                  bit_d   = 3'd0;
                  state_d = rx_s ? IDLE : DATA;
               end
            end
         end
         DATA: begin
            if (tick16_i) begin
               tick_d = tick_q + 4'd1;
               if (tick_q == 4'd15) begin
                  shift_d = {rx_s, shift_q[7:1]};
                  bit_d   = bit_q + 3'd1;
                  if (bit_q == 3'd7) state_d = STOP;
               end
            end
         end
         default: begin
            if (tick16_i) begin
               tick_d = tick_q + 4'd1;
               if (tick_q == 4'd15) begin
                  strobe_d = 1'b1;
                  err_d    = ~rx_s;
                  state_d  = IDLE;
               end
            end
         end
      endcase
   end

   assign byte_strobe_o = strobe_q;
   assign byte_out_o    = shift_q;
   assign frame_err_o   = err_q;

endmodule

`default_nettype wire

// File: rtl/uart_periph.sv
// ============================================================================
// uart_periph : memory-mapped UART (TXD/RXD/CON), tick generator, TX FSM
//               optional interrupt logic enabled by defining UART_IRQ_EN
// Rev 1.0     : initial release
// ============================================================================
`default_nettype none

module uart_periph
   import uart_pkg::*;
#(
   parameter int CLK_HZ = 50_000_000,
   parameter int BAUD   = 9600
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        MemRead,
   input  logic        MemWrite,
   output logic [31:0] rdata,
   input  logic        rx,
   output logic        tx,
   output logic        irq
);

   localparam int DIV = CLK_HZ / (BAUD * 16);
   localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;

   logic [TW-1:0] tick_cnt_q;
   logic          tick16;
   logic          sel_txd, sel_rxd, sel_con;
   logic          wr_txd, rd_rxd, rd_con;
   uart_state_t   tx_state_q, tx_state_d;
   logic [3:0]    tx_tick_q, tx_tick_d;
   logic [2:0]    tx_bit_q, tx_bit_d;
   logic          tx_busy, tx_finish;
   logic [7:0]    txd_q, rx_byte_q;
   logic          rx_valid_q, rx_ovr_q, tx_done_q;
   logic          rx_ie, tx_ie;
   logic          rx_strobe, rx_ferr, deliver;
   logic [7:0]    rx_data;
   logic [31:0]   con_val;
   logic          unused_bits;

   assign unused_bits = ^{wdata[31:8], addr[1:0]};

   assign sel_txd = (addr[31:2] == UART_TXD_ADDR[31:2]);
   assign sel_rxd = (addr[31:2] == UART_RXD_ADDR[31:2]);
   assign sel_con = (addr[31:2] == UART_CON_ADDR[31:2]);
   assign wr_txd  = MemWrite & sel_txd;
   assign rd_rxd  = MemRead & sel_rxd;
   assign rd_con  = MemRead & sel_con;

   assign tick16 = (tick_cnt_q == TW'(DIV - 1));

   always_ff @(posedge clk) begin
      if (rst)         tick_cnt_q <= '0;
      else if (tick16) tick_cnt_q <= '0;
      else             tick_cnt_q <= tick_cnt_q + 1'b1;
   end

   uart_rx_core u_rx_core (
      .clk           (clk),
      .rst           (rst),
      .tick16_i      (tick16),
      .rx_i          (rx),
      .byte_strobe_o (rx_strobe),
      .byte_out_o    (rx_data),
      .frame_err_o   (rx_ferr)
   );

   assign deliver = rx_strobe & ~rx_ferr;

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state_q <= IDLE;
         tx_tick_q  <= 4'd0;
         tx_bit_q   <= 3'd0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_tick_q  <= tx_tick_d;
         tx_bit_q   <= tx_bit_d;
      end
   end

   always_comb begin
      tx_state_d = tx_state_q;
      tx_tick_d  = tx_tick_q;
      tx_bit_d   = tx_bit_q;
      tx_finish  = 1'b0;
      if (tx_state_q == IDLE) begin
         if (wr_txd) begin
            tx_state_d = START;
            tx_tick_d  = 4'd0;
            tx_bit_d   = 3'd0;
         end
      end else if (tick16) begin
         tx_tick_d = tx_tick_q + 4'd1;
         if (tx_tick_q == 4'd15) begin
            case (tx_state_q)
               START:   tx_state_d = DATA;
               DATA: begin
                  tx_bit_d = tx_bit_q + 3'd1;
                  if (tx_bit_q == 3'd7) tx_state_d = STOP;
               end
               default: begin
                  tx_state_d = IDLE;
                  tx_finish  = 1'b1;
               end
            endcase
         end
      end
   end

   // txd_q is frozen while busy, so it doubles as the transmit shift source.
   always_comb begin
      tx = 1'b1;
      case (tx_state_q)
         START:   tx = 1'b0;
         DATA:    tx = txd_q[tx_bit_q];
         default: tx = 1'b1;
      endcase
   end

   assign tx_busy = (tx_state_q != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         txd_q      <= 8'd0;
         rx_byte_q  <= 8'd0;
         rx_valid_q <= 1'b0;
         rx_ovr_q   <= 1'b0;
         tx_done_q  <= 1'b0;
      end else begin
         if (wr_txd && !tx_busy) txd_q <= wdata[7:0];
         if (tx_finish)   tx_done_q <= 1'b1;
         else if (rd_con) tx_done_q <= 1'b0;
         // A same-cycle RXD read frees the holding register for the new byte.
         if (deliver && (!rx_valid_q || rd_rxd)) begin
            rx_byte_q  <= rx_data;
            rx_valid_q <= 1'b1;
         end else if (rd_rxd) begin
            rx_valid_q <= 1'b0;
         end
         if (deliver && rx_valid_q && !rd_rxd) rx_ovr_q <= 1'b1;
         else if (rd_con)                      rx_ovr_q <= 1'b0;
      end
   end

`ifdef UART_IRQ_EN
   logic rx_ie_q, tx_ie_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_ie_q <= 1'b0;
         tx_ie_q <= 1'b0;
      end else if (MemWrite && sel_con) begin
         rx_ie_q <= wdata[CON_RX_IE];
         tx_ie_q <= wdata[CON_TX_IE];
      end
   end

   assign rx_ie = rx_ie_q;
   assign tx_ie = tx_ie_q;
   assign irq   = (rx_valid_q & rx_ie_q) | (tx_done_q & tx_ie_q);
`else
   assign rx_ie = 1'b0;
   assign tx_ie = 1'b0;
   assign irq   = 1'b0;
`endif

   always_comb begin
      con_val               = 32'd0;
      con_val[CON_RX_VALID] = rx_valid_q;
      con_val[CON_TX_BUSY]  = tx_busy;
      con_val[CON_TX_DONE]  = tx_done_q;
      con_val[CON_RX_OVR]   = rx_ovr_q;
      con_val[CON_RX_IE]    = rx_ie;
      con_val[CON_TX_IE]    = tx_ie;
   end

   always_comb begin
      rdata = 32'd0;
      if (MemRead) begin
         if (sel_txd)      rdata = {24'd0, txd_q};
         else if (sel_rxd) rdata = {24'd0, rx_byte_q};
         else if (sel_con) rdata = con_val;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_uart_periph.sv
// ============================================================================
// tb_uart_periph : directed self-checking bench for uart_periph (DIV=10)
// Rev 1.0        : initial release
// ============================================================================
`default_nettype none

module tb_uart_periph;

   localparam int          BIT   = 160;
   localparam logic [31:0] A_TXD = 32'h4000_0018;
   localparam logic [31:0] A_RXD = 32'h4000_001C;
   localparam logic [31:0] A_CON = 32'h4000_0020;

   logic        clk = 1'b0;
   logic        rst, MemRead, MemWrite, rx, tx, irq;
   logic [31:0] addr, wdata, rdata;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   uart_periph #(.CLK_HZ(1_600_000), .BAUD(10_000)) dut (
      .clk      (clk),
      .rst      (rst),
      .addr     (addr),
      .wdata    (wdata),
      .MemRead  (MemRead),
      .MemWrite (MemWrite),
      .rdata    (rdata),
      .rx       (rx),
      .tx       (tx),
      .irq      (irq)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      addr = a; wdata = d; MemWrite = 1'b1;
      @(negedge clk);
      MemWrite = 1'b0; addr = 32'd0; wdata = 32'd0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      @(negedge clk);
      addr = a; MemRead = 1'b1;
      #1 d = rdata;
      @(negedge clk);
      MemRead = 1'b0; addr = 32'd0;
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop_lvl);
      rx = 1'b0;
      wait_cyc(BIT);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         wait_cyc(BIT);
      end
      rx = stop_lvl;
      if (stop_lvl) begin
         wait_cyc(BIT);
      end else begin
         wait_cyc(100);
         rx = 1'b1;
         wait_cyc(BIT - 100);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [31:0] d;
      logic [7:0]  txb;
      int          low_cnt;

      rst = 1'b1; addr = 32'd0; wdata = 32'd0;
      MemRead = 1'b0; MemWrite = 1'b0; rx = 1'b1;
      wait_cyc(3);
      rst = 1'b0;
      wait_cyc(2);

      chk("rst_tx", tx, 1);
      chk("rst_irq", irq, 0);
      chk("rst_rdata_idle", rdata, 0);
      bus_read(A_CON, d);          chk("rst_con", d, 0);
      bus_read(A_RXD, d);          chk("rst_rxd", d, 0);
      bus_read(A_TXD, d);          chk("rst_txd", d, 0);
      bus_read(32'h4000_0024, d);  chk("unmapped_read", d, 0);

      // ---- transmit 0xA5 ----
      bus_write(A_TXD, 32'hFFFF_FFA5);
      low_cnt = 0;
      while (tx == 1'b0 && low_cnt < 200) begin
         low_cnt++;
         @(negedge clk);
      end
      chk("tx_start_len_ok", (low_cnt >= 151 && low_cnt <= 160), 1);
      wait_cyc(80);
      txb = 8'd0;
      for (int i = 0; i < 8; i++) begin
         txb[i] = tx;
         if (i < 7) wait_cyc(BIT);
      end
      chk("tx_data_bits", txb, 8'hA5);
      wait_cyc(BIT);
      chk("tx_stop_level", tx, 1);
      bus_read(A_CON, d);          chk("con_busy_in_stop", d, 32'h02);
      bus_write(A_TXD, 32'h5A);
      wait_cyc(100);
      bus_read(A_CON, d);          chk("con_tx_done", d, 32'h04);
      bus_read(A_CON, d);          chk("con_done_cleared", d, 32'h00);
      bus_read(A_TXD + 3, d);      chk("txd_busy_write_ignored", d, 32'hA5);
      chk("tx_idle_after_frame", tx, 1);

      // ---- receive 0x3C ----
      send_rx(8'h3C, 1'b1);
      wait_cyc(5);
      bus_read(A_CON, d);          chk("rx_valid_set", d, 32'h01);
      bus_read(A_RXD, d);          chk("rxd_3c", d, 32'h0000_003C);
      bus_read(A_CON, d);          chk("rx_valid_cleared", d, 32'h00);

      // ---- overrun: 0x11 then 0x22 unread ----
      send_rx(8'h11, 1'b1);
      send_rx(8'h22, 1'b1);
      wait_cyc(5);
      bus_read(A_CON, d);          chk("con_overrun", d, 32'h09);
      bus_read(A_RXD, d);          chk("rxd_kept_first", d, 32'h11);
      bus_read(A_CON, d);          chk("con_after_overrun", d, 32'h00);

      // ---- 3-cycle glitch, then a good byte proves the FSM is idle ----
      @(negedge clk);
      rx = 1'b0;
      wait_cyc(3);
      rx = 1'b1;
      wait_cyc(300);
      bus_read(A_CON, d);          chk("glitch_no_flag", d, 32'h00);
      send_rx(8'h5A, 1'b1);
      wait_cyc(5);
      bus_read(A_RXD, d);          chk("rxd_after_glitch", d, 32'h5A);

      // ---- framing error discarded ----
      send_rx(8'h77, 1'b0);
      wait_cyc(300);
      bus_read(A_CON, d);          chk("ferr_no_flag", d, 32'h00);
      bus_read(A_RXD, d);          chk("ferr_byte_kept", d, 32'h5A);

      // ---- interrupt enable ----
`ifdef UART_IRQ_EN
      bus_write(A_CON, 32'h10);
      bus_read(A_CON, d);          chk("con_rx_ie", d, 32'h10);
      send_rx(8'h42, 1'b1);
      wait_cyc(5);
      chk("irq_on_rx", irq, 1);
      bus_read(A_RXD, d);          chk("rxd_42", d, 32'h42);
      chk("irq_cleared", irq, 0);
      bus_write(A_CON, 32'h00);
`else
      bus_write(A_CON, 32'h30);
      bus_read(A_CON, d);          chk("con_ie_ignored", d, 32'h00);
      send_rx(8'h42, 1'b1);
      wait_cyc(5);
      chk("irq_tied_low", irq, 0);
      bus_read(A_RXD, d);          chk("rxd_42", d, 32'h42);
`endif

      // ---- reset during a TX data bit ----
      bus_write(A_TXD, 32'h00);
      wait_cyc(400);
      chk("tx_mid_frame_low", tx, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("tx_high_after_rst", tx, 1);
      bus_read(A_CON, d);          chk("con_after_rst", d, 32'h00);
      bus_read(A_TXD, d);          chk("txd_after_rst", d, 32'h00);
      wait_cyc(200);
      chk("tx_stays_idle", tx, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
